// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
//   N_CH independent push-button debouncers. Each channel polarity-adjusts its
//   raw pin, passes it through a SYNC_STAGES flop synchroniser and qualifies
//   the synchronised level s with a stable-time counter in both directions.
//   The qualified level and single-cycle press/release pulses are registered.
//
// Ports
//   clk      in   1     system clock, rising edge
//   rst_n    in   1     asynchronous active-low reset
//   btn_in   in   N_CH  raw asynchronous button pins
//   btn_db   out  N_CH  debounced level, 1 = pressed
//   btn_rise out  N_CH  one-cycle pulse on btn_db 0->1
//   btn_fall out  N_CH  one-cycle pulse on btn_db 1->0
//   busy     out  N_CH  1 while the channel's stable-time counter runs
// -----------------------------------------------------------------------------
module debounce_bank #(
  parameter int N_CH        = 4,
  parameter int CNT_MAX     = 500000,
  parameter int CNT_W       = 19,
  parameter int SYNC_STAGES = 2,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_db,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] busy
);

  typedef enum logic [1:0] {
    ST_REL   = 2'd0,
    ST_CHK_P = 2'd1,
    ST_PRS   = 2'd2,
    ST_CHK_R = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  // With CNT_MAX=1 the first stable cycle already qualifies, so the
  // checking states are skipped entirely.
  localparam bit SINGLE_CYCLE = (CNT_MAX == 1);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_s;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;
    logic                   r_db;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_busy;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Synchroniser chain; resets to the released level so no pulse follows reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync <= {SYNC_STAGES{1'b0}};
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in[g] ^ ACTIVE_LOW};
      end
    end

    // State, counter and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_REL;
        r_cnt   <= CNT_ZERO;
        r_db    <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_db    <= (w_state_nxt == ST_PRS) || (w_state_nxt == ST_CHK_R);
        r_busy  <= (w_state_nxt == ST_CHK_P) || (w_state_nxt == ST_CHK_R);
        r_rise  <= w_rise_nxt;
        r_fall  <= w_fall_nxt;
      end
    end

    // Next-state logic. The cycle in which a new level is first seen in
    // REL/PRS counts as stable cycle one, so the checking state starts at
    // cnt=1 and acceptance at cnt=CNT_MAX-1 lands SYNC_STAGES+CNT_MAX cycles
    // after the pin change. A reversal is tested before the terminal count,
    // so it wins over acceptance in the same cycle.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (r_state)
        ST_REL: begin
          if (w_s) begin
            if (SINGLE_CYCLE) begin
              w_state_nxt = ST_PRS;
              w_cnt_nxt   = CNT_ZERO;
              w_rise_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_CHK_P;
              w_cnt_nxt   = CNT_ONE;
            end
          end else begin
            w_cnt_nxt = CNT_ZERO;
          end
        end
        ST_CHK_P: begin
          if (!w_s) begin
            w_state_nxt = ST_REL;
            w_cnt_nxt   = CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_PRS;
            w_cnt_nxt   = CNT_ZERO;
            w_rise_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        ST_PRS: begin
          if (!w_s) begin
            if (SINGLE_CYCLE) begin
              w_state_nxt = ST_REL;
              w_cnt_nxt   = CNT_ZERO;
              w_fall_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_CHK_R;
              w_cnt_nxt   = CNT_ONE;
            end
          end else begin
            w_cnt_nxt = CNT_ZERO;
          end
        end
        ST_CHK_R: begin
          if (w_s) begin
            w_state_nxt = ST_PRS;
            w_cnt_nxt   = CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_REL;
            w_cnt_nxt   = CNT_ZERO;
            w_fall_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_REL;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end

    assign btn_db[g]   = r_db;
    assign btn_rise[g] = r_rise;
    assign btn_fall[g] = r_fall;
    assign busy[g]     = r_busy;
  end

endmodule
